ct_sysio_kid_mc: RTL and testbench
==================================

// Module: ct_sysio_kid_mc
// PURPOSE
//  Multi-core sysio interface slice between pads/PLIC/CLINT and per-core PIU. Syncs N interrupt lines per core
//  through a clock-enabled chain, debounces debug requests, registers low-power/JDB status, and runs a
//  per-core low-power wakeup handshake. Generalises the single-core sysio kid: CORE_NUM, INT_NUM, sync depth, filter.
// PARAMETERS
//  CORE_NUM     4  number of cores served
//  INT_NUM      6  interrupt lines per core; bit order {st,mt,ss,ms,se,me}, me=bit0
//  SYNC_STAGES  2  interrupt sync depth, >=1, advances only on apb_clk_en
//  DBG_FLT      3  consecutive equal axim_clk_en samples before dbgrq_b output changes, >=1
// PORTS
//  sysio_clk            in  1                  clock
//  cpurst               in  1                  async active-high reset
//  apb_clk_en           in  1                  interrupt sampling enable
//  axim_clk_en          in  1                  pad/PIU sampling enable
//  int_in               in  CORE_NUM*INT_NUM   raw PLIC/CLINT levels, core c at [c*INT_NUM +: INT_NUM]
//  pad_core_dbgrq_b     in  CORE_NUM           raw debug request, active-low
//  pad_core_dbg_mask    in  1                  debug mask
//  piu_sysio_lpmd_b     in  2*CORE_NUM         per-core low-power mode, 2'b11 = running
//  piu_sysio_jdb_pm     in  2*CORE_NUM         per-core JDB power mode
//  sysio_piu_int        out CORE_NUM*INT_NUM   synchronised interrupt levels
//  sysio_piu_dbgrq_b    out CORE_NUM           filtered debug request, active-low
//  sysio_had_dbg_mask_x out 1                  registered debug mask
//  sysio_piu_wakeup     out CORE_NUM           wakeup request, level, held until core runs
//  core_pad_lpmd_b      out 2*CORE_NUM         registered lpmd_b
//  core_pad_jdb_pm      out 2*CORE_NUM         registered jdb_pm
//  sysio_cluster_lpmd   out 1                  1 when every core's registered lpmd_b != 2'b11
// BEHAVIOUR
//  Reset (cpurst=1, async): sync chains 0, sysio_piu_int 0, dbgrq_b 1, filter counters 0, dbg_mask_x 0,
//   lpmd_b all 2'b11, jdb_pm 0, wakeup 0, cluster_lpmd 0, all FSMs RUN. Reset mid-operation aborts handshake.
//  Interrupts: each chain shifts only on sysio_clk edges with apb_clk_en=1; output = last stage, latency
//   SYNC_STAGES enabled edges. No edge detect; levels pass through.
//  Dbg filter per core, updates only when axim_clk_en=1: raw != current output -> cnt+1, else cnt=0;
//   on cnt reaching DBG_FLT-1 with raw still differing, output <= raw, cnt <= 0. Counter never wraps.
//   DBG_FLT=1: output follows raw with 1 enabled-cycle latency.
//  dbg_mask_x, lpmd_b, jdb_pm registered on axim_clk_en; hold otherwise.
//  Wakeup FSM per core, transitions on axim_clk_en edges, using registered lpmd_b:
//   RUN  -> LPMD when lpmd_b != 2'b11.
//   LPMD -> WAKE when |sysio_piu_int[core] or dbgrq_b==0; same-cycle return to 2'b11 -> RUN (priority).
//   WAKE -> RUN  when lpmd_b == 2'b11; wakeup=1 exactly in WAKE, registered output.
//   Interrupt dropping while in WAKE keeps WAKE (request is sticky).
//  cluster_lpmd registered from AND of per-core (lpmd_b != 2'b11), updated on axim_clk_en.
//  Enable low -> every register holds; no output changes.
// STRUCTURE
//  Shared package/header: FSM encodings (RUN=2'd0,LPMD=2'd1,WAKE=2'd2), LPMD_RUN=2'b11, interrupt bit indices.
//  Sub-module ct_sysio_kid_core: one core's sync chain, dbg filter, lpmd/jdb regs, FSM; generate x CORE_NUM.
//  Top holds dbg_mask_x and cluster_lpmd only.
// TESTING
//  Reset release, all enables 1 -> every output at reset value; int 0x01 core0 -> sysio_piu_int[0]=1 after 2 edges.
//  apb_clk_en every 4th cycle, int pulse on core2 bit5 -> appears after 2 enabled edges, never earlier.
//  dbgrq_b glitch low for 2 enabled samples, DBG_FLT=3 -> no change; held low 3 samples -> output 0.
//  Core1 lpmd_b=2'b01, then int bit3 -> wakeup[1]=1, held; lpmd_b=2'b11 -> wakeup[1]=0, FSM RUN.
//  All 4 cores lpmd_b=2'b10 -> cluster_lpmd=1; core3 back to 2'b11 -> 0 next enabled edge.
//  cpurst asserted while core0 in WAKE -> wakeup 0 immediately, lpmd_b 2'b11; release -> RUN.

Source files
------------

// File: rtl/ct_sysio_kid_mc_pkg.sv
// Shared encodings for the multi-core sysio kid: wakeup FSM states, the lpmd "running" code
// and interrupt bit positions within one core's interrupt group.
package ct_sysio_kid_mc_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StLpmd = 2'd1,
    StWake = 2'd2
  } wk_state_e;

  localparam logic [1:0] LPMD_RUN = 2'b11;

  localparam int unsigned INT_ME = 0;
  localparam int unsigned INT_SE = 1;
  localparam int unsigned INT_MS = 2;
  localparam int unsigned INT_SS = 3;
  localparam int unsigned INT_MT = 4;
  localparam int unsigned INT_ST = 5;

  function automatic logic is_lowpower(input logic [1:0] lpmd_b);
    return lpmd_b != LPMD_RUN;
  endfunction

endpackage

// File: rtl/ct_sysio_kid_mc_if.sv
// Pad/PLIC/CLINT/PIU-facing signal bundle of the multi-core sysio kid.
// master = pad/PIU side driving the raw inputs, slave = the sysio kid.
interface ct_sysio_kid_mc_if #(
  parameter int unsigned CORE_NUM = 4,
  parameter int unsigned INT_NUM  = 6
);
  logic                         apb_clk_en;
  logic                         axim_clk_en;
  logic [CORE_NUM*INT_NUM-1:0]  int_in;
  logic [CORE_NUM-1:0]          pad_core_dbgrq_b;
  logic                         pad_core_dbg_mask;
  logic [2*CORE_NUM-1:0]        piu_sysio_lpmd_b;
  logic [2*CORE_NUM-1:0]        piu_sysio_jdb_pm;
  logic [CORE_NUM*INT_NUM-1:0]  sysio_piu_int;
  logic [CORE_NUM-1:0]          sysio_piu_dbgrq_b;
  logic                         sysio_had_dbg_mask_x;
  logic [CORE_NUM-1:0]          sysio_piu_wakeup;
  logic [2*CORE_NUM-1:0]        core_pad_lpmd_b;
  logic [2*CORE_NUM-1:0]        core_pad_jdb_pm;
  logic                         sysio_cluster_lpmd;

  modport master (
    output apb_clk_en, axim_clk_en, int_in, pad_core_dbgrq_b, pad_core_dbg_mask,
           piu_sysio_lpmd_b, piu_sysio_jdb_pm,
    input  sysio_piu_int, sysio_piu_dbgrq_b, sysio_had_dbg_mask_x, sysio_piu_wakeup,
           core_pad_lpmd_b, core_pad_jdb_pm, sysio_cluster_lpmd
  );

  modport slave (
    input  apb_clk_en, axim_clk_en, int_in, pad_core_dbgrq_b, pad_core_dbg_mask,
           piu_sysio_lpmd_b, piu_sysio_jdb_pm,
    output sysio_piu_int, sysio_piu_dbgrq_b, sysio_had_dbg_mask_x, sysio_piu_wakeup,
           core_pad_lpmd_b, core_pad_jdb_pm, sysio_cluster_lpmd
  );
endinterface

// File: rtl/ct_sysio_kid_core.sv
// One core's slice: interrupt sync chain, debug-request debounce, lpmd/jdb registers and the
// low-power wakeup handshake FSM.
module ct_sysio_kid_core
  import ct_sysio_kid_mc_pkg::*;
#(
  parameter int unsigned INT_NUM     = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBG_FLT     = 3
) (
  input  logic               sysio_clk,
  input  logic               cpurst,
  input  logic               apb_clk_en,
  input  logic               axim_clk_en,
  input  logic [INT_NUM-1:0] int_in,
  input  logic               dbgrq_b_raw,
  input  logic [1:0]         lpmd_b_in,
  input  logic [1:0]         jdb_pm_in,
  output logic [INT_NUM-1:0] int_out,
  output logic               dbgrq_b,
  output logic               wakeup,
  output logic [1:0]         lpmd_b,
  output logic [1:0]         jdb_pm
);

  localparam int unsigned CntW = (DBG_FLT > 1) ? $clog2(DBG_FLT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DBG_FLT - 1);

  logic [SYNC_STAGES-1:0][INT_NUM-1:0] sync_q;
  logic                                dbg_q, dbg_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [1:0]                          lpmd_q, jdb_q;
  wk_state_e                           state_q, state_d;
  logic                                wakeup_q, wakeup_d;

  always_ff @(posedge sysio_clk or posedge cpurst) begin
    if (cpurst) begin
      sync_q <= '0;
    end else if (apb_clk_en) begin
      sync_q[0] <= int_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Output flips only after DBG_FLT consecutive differing samples; any agreeing sample restarts.
  always_comb begin
    dbg_d = dbg_q;
    cnt_d = '0;
    if (dbgrq_b_raw != dbg_q) begin
      if (cnt_q == CntMax) begin
        dbg_d = dbgrq_b_raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Return to running takes priority over a pending wake cause.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:  if (is_lowpower(lpmd_q)) state_d = StLpmd;
      StLpmd: begin
        if (!is_lowpower(lpmd_q))          state_d = StRun;
        else if (|sync_q[SYNC_STAGES-1] || !dbg_q) state_d = StWake;
      end
      StWake: if (!is_lowpower(lpmd_q)) state_d = StRun;
      default: state_d = StRun;
    endcase
    wakeup_d = (state_d == StWake);
  end

  always_ff @(posedge sysio_clk or posedge cpurst) begin
    if (cpurst) begin
      dbg_q    <= 1'b1;
      cnt_q    <= '0;
      lpmd_q   <= LPMD_RUN;
      jdb_q    <= 2'b00;
      state_q  <= StRun;
      wakeup_q <= 1'b0;
    end else if (axim_clk_en) begin
      dbg_q    <= dbg_d;
      cnt_q    <= cnt_d;
      lpmd_q   <= lpmd_b_in;
      jdb_q    <= jdb_pm_in;
      state_q  <= state_d;
      wakeup_q <= wakeup_d;
    end
  end

  assign int_out = sync_q[SYNC_STAGES-1];
  assign dbgrq_b = dbg_q;
  assign wakeup  = wakeup_q;
  assign lpmd_b  = lpmd_q;
  assign jdb_pm  = jdb_q;

endmodule

// File: rtl/ct_sysio_kid_mc.sv
// Multi-core sysio kid top: replicates the per-core slice and owns the cluster-wide
// debug mask and cluster low-power status registers.
module ct_sysio_kid_mc
  import ct_sysio_kid_mc_pkg::*;
#(
  parameter int unsigned CORE_NUM    = 4,
  parameter int unsigned INT_NUM     = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBG_FLT     = 3
) (
  input logic             sysio_clk,
  input logic             cpurst,
  ct_sysio_kid_mc_if.slave sio
);

  logic [CORE_NUM*INT_NUM-1:0] int_w;
  logic [CORE_NUM-1:0]         dbgrq_w;
  logic [CORE_NUM-1:0]         wakeup_w;
  logic [2*CORE_NUM-1:0]       lpmd_w;
  logic [2*CORE_NUM-1:0]       jdb_w;
  logic [CORE_NUM-1:0]         core_lp;
  logic                        mask_q;
  logic                        cluster_q;

  for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
    ct_sysio_kid_core #(
      .INT_NUM    (INT_NUM),
      .SYNC_STAGES(SYNC_STAGES),
      .DBG_FLT    (DBG_FLT)
    ) u_core (
      .sysio_clk  (sysio_clk),
      .cpurst     (cpurst),
      .apb_clk_en (sio.apb_clk_en),
      .axim_clk_en(sio.axim_clk_en),
      .int_in     (sio.int_in[c*INT_NUM +: INT_NUM]),
      .dbgrq_b_raw(sio.pad_core_dbgrq_b[c]),
      .lpmd_b_in  (sio.piu_sysio_lpmd_b[2*c +: 2]),
      .jdb_pm_in  (sio.piu_sysio_jdb_pm[2*c +: 2]),
      .int_out    (int_w[c*INT_NUM +: INT_NUM]),
      .dbgrq_b    (dbgrq_w[c]),
      .wakeup     (wakeup_w[c]),
      .lpmd_b     (lpmd_w[2*c +: 2]),
      .jdb_pm     (jdb_w[2*c +: 2])
    );
    assign core_lp[c] = is_lowpower(lpmd_w[2*c +: 2]);
  end

  always_ff @(posedge sysio_clk or posedge cpurst) begin
    if (cpurst) begin
      mask_q    <= 1'b0;
      cluster_q <= 1'b0;
    end else if (sio.axim_clk_en) begin
      mask_q    <= sio.pad_core_dbg_mask;
      cluster_q <= &core_lp;
    end
  end

  assign sio.sysio_piu_int        = int_w;
  assign sio.sysio_piu_dbgrq_b    = dbgrq_w;
  assign sio.sysio_piu_wakeup     = wakeup_w;
  assign sio.core_pad_lpmd_b      = lpmd_w;
  assign sio.core_pad_jdb_pm      = jdb_w;
  assign sio.sysio_had_dbg_mask_x = mask_q;
  assign sio.sysio_cluster_lpmd   = cluster_q;

endmodule

// File: tb/tb_ct_sysio_kid_mc.sv
// Directed + randomised bench for ct_sysio_kid_mc against a behavioural model of the sysio rules.
module tb_ct_sysio_kid_mc;

  localparam int CN  = 4;
  localparam int IN  = 6;
  localparam int SS  = 2;
  localparam int FLT = 3;

  logic sysio_clk = 1'b0;
  logic cpurst    = 1'b1;
  always #5 sysio_clk = ~sysio_clk;

  ct_sysio_kid_mc_if #(.CORE_NUM(CN), .INT_NUM(IN)) sio ();

  ct_sysio_kid_mc #(
    .CORE_NUM(CN), .INT_NUM(IN), .SYNC_STAGES(SS), .DBG_FLT(FLT)
  ) dut (
    .sysio_clk(sysio_clk),
    .cpurst   (cpurst),
    .sio      (sio)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  // Model state: interrupt delay line, debug run lengths, wakeup modes (0 run, 1 asleep, 2 waking)
  logic [CN*IN-1:0] m_int_q[$];
  logic [CN-1:0]    m_dbg;
  int               m_run[CN];
  int               m_mode[CN];
  logic [2*CN-1:0]  m_lpmd, m_jdb;
  logic             m_mask, m_cluster;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_int_q = {};
    for (int i = 0; i < SS; i++) m_int_q.push_back('0);
    m_dbg = '1;
    m_lpmd = '1;
    m_jdb = '0;
    m_mask = 1'b0;
    m_cluster = 1'b0;
    for (int c = 0; c < CN; c++) begin
      m_run[c] = 0;
      m_mode[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [CN*IN-1:0] oi;
    logic [CN-1:0]    od;
    logic [2*CN-1:0]  ol;
    bit               all_lp;
    oi = m_int_q[0];
    od = m_dbg;
    ol = m_lpmd;
    if (sio.axim_clk_en) begin
      all_lp = 1;
      for (int c = 0; c < CN; c++) begin
        logic [1:0] l;
        logic raw;
        l = ol[2*c +: 2];
        if (l == 2'b11) all_lp = 0;
        case (m_mode[c])
          0: if (l != 2'b11) m_mode[c] = 1;
          1: if (l == 2'b11) m_mode[c] = 0;
             else if ((|oi[IN*c +: IN]) || !od[c]) m_mode[c] = 2;
          default: if (l == 2'b11) m_mode[c] = 0;
        endcase
        raw = sio.pad_core_dbgrq_b[c];
        if (raw != m_dbg[c]) begin
          m_run[c]++;
          if (m_run[c] == FLT) begin
            m_dbg[c] = raw;
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_cluster = all_lp;
      m_lpmd = sio.piu_sysio_lpmd_b;
      m_jdb  = sio.piu_sysio_jdb_pm;
      m_mask = sio.pad_core_dbg_mask;
    end
    if (sio.apb_clk_en) begin
      m_int_q.push_back(sio.int_in);
      void'(m_int_q.pop_front());
    end
  endtask

  function automatic logic [CN-1:0] m_wake();
    logic [CN-1:0] w;
    for (int c = 0; c < CN; c++) w[c] = (m_mode[c] == 2);
    return w;
  endfunction

  always @(negedge sysio_clk) begin
    if (chk_on) begin
      chk("int",     sio.sysio_piu_int,        m_int_q[0]);
      chk("dbgrq_b", sio.sysio_piu_dbgrq_b,    m_dbg);
      chk("wakeup",  sio.sysio_piu_wakeup,     m_wake());
      chk("lpmd_b",  sio.core_pad_lpmd_b,      m_lpmd);
      chk("jdb_pm",  sio.core_pad_jdb_pm,      m_jdb);
      chk("mask",    sio.sysio_had_dbg_mask_x, m_mask);
      chk("cluster", sio.sysio_cluster_lpmd,   m_cluster);
    end
  end

  task automatic tick();
    @(posedge sysio_clk);
    if (cpurst) model_reset();
    else model_step();
    @(negedge sysio_clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int en_cnt;
    sio.apb_clk_en = 1'b1;
    sio.axim_clk_en = 1'b1;
    sio.int_in = '0;
    sio.pad_core_dbgrq_b = '1;
    sio.pad_core_dbg_mask = 1'b0;
    sio.piu_sysio_lpmd_b = '1;
    sio.piu_sysio_jdb_pm = '0;
    model_reset();
    chk_on = 1;
    ticks(3);
    cpurst = 1'b0;
    ticks(2);
    chk("rst_int", sio.sysio_piu_int, 24'h0);
    chk("rst_dbgrq", sio.sysio_piu_dbgrq_b, 4'hF);
    chk("rst_lpmd", sio.core_pad_lpmd_b, 8'hFF);
    chk("rst_wakeup", sio.sysio_piu_wakeup, 4'h0);
    chk("rst_cluster", sio.sysio_cluster_lpmd, 1'b0);

    // Core0 interrupt 0x01 through a two-stage chain
    sio.int_in = 24'h000001;
    tick();
    chk("int_lat1", sio.sysio_piu_int, 24'h0);
    tick();
    chk("int_lat2", sio.sysio_piu_int, 24'h000001);
    sio.int_in = '0;
    ticks(3);

    // Sparse apb enable: core2 bit5 appears only after the second enabled edge
    sio.int_in = 24'h020000;
    en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sio.apb_clk_en = (i % 4 == 3);
      tick();
      if (sio.apb_clk_en) en_cnt++;
      chk("apb_gate", sio.sysio_piu_int[17], (en_cnt >= 2));
    end
    sio.apb_clk_en = 1'b1;
    sio.int_in = '0;
    ticks(3);

    // Debug debounce: 2-sample glitch ignored, 3-sample low accepted
    sio.pad_core_dbgrq_b = 4'hE;
    ticks(2);
    sio.pad_core_dbgrq_b = 4'hF;
    tick();
    chk("dbg_glitch", sio.sysio_piu_dbgrq_b, 4'hF);
    sio.pad_core_dbgrq_b = 4'hE;
    ticks(2);
    chk("dbg_two", sio.sysio_piu_dbgrq_b, 4'hF);
    tick();
    chk("dbg_three", sio.sysio_piu_dbgrq_b, 4'hE);
    sio.pad_core_dbgrq_b = 4'hF;
    ticks(3);
    chk("dbg_back", sio.sysio_piu_dbgrq_b, 4'hF);

    // Core1 sleeps, bit3 interrupt wakes it, request sticks until running again
    sio.piu_sysio_lpmd_b = 8'hF7;
    ticks(3);
    sio.int_in = 24'h000200;
    ticks(2);
    chk("wake_early", sio.sysio_piu_wakeup, 4'h0);
    tick();
    chk("wake_set", sio.sysio_piu_wakeup, 4'h2);
    sio.int_in = '0;
    ticks(3);
    chk("wake_sticky", sio.sysio_piu_wakeup, 4'h2);
    sio.piu_sysio_lpmd_b = 8'hFF;
    tick();
    chk("wake_hold", sio.sysio_piu_wakeup, 4'h2);
    tick();
    chk("wake_clr", sio.sysio_piu_wakeup, 4'h0);
    ticks(2);

    // Cluster low power, axim gating and core3 return
    sio.piu_sysio_lpmd_b = 8'hAA;
    sio.piu_sysio_jdb_pm = 8'h1B;
    sio.pad_core_dbg_mask = 1'b1;
    tick();
    chk("jdb_reg", sio.core_pad_jdb_pm, 8'h1B);
    chk("mask_reg", sio.sysio_had_dbg_mask_x, 1'b1);
    chk("cluster_lat", sio.sysio_cluster_lpmd, 1'b0);
    tick();
    chk("cluster_set", sio.sysio_cluster_lpmd, 1'b1);
    sio.axim_clk_en = 1'b0;
    sio.piu_sysio_lpmd_b = 8'h00;
    sio.piu_sysio_jdb_pm = 8'h5A;
    sio.pad_core_dbg_mask = 1'b0;
    ticks(3);
    chk("hold_lpmd", sio.core_pad_lpmd_b, 8'hAA);
    chk("hold_jdb", sio.core_pad_jdb_pm, 8'h1B);
    chk("hold_mask", sio.sysio_had_dbg_mask_x, 1'b1);
    sio.axim_clk_en = 1'b1;
    sio.piu_sysio_lpmd_b = 8'hEA;
    tick();
    chk("cluster_hold1", sio.sysio_cluster_lpmd, 1'b1);
    tick();
    chk("cluster_clr", sio.sysio_cluster_lpmd, 1'b0);
    sio.piu_sysio_lpmd_b = 8'hFF;
    ticks(3);

    // Async reset while core0 is in WAKE
    sio.piu_sysio_lpmd_b = 8'hFD;
    ticks(3);
    sio.int_in = 24'h000001;
    ticks(3);
    chk("wake0_set", sio.sysio_piu_wakeup, 4'h1);
    #2;
    cpurst = 1'b1;
    #1;
    chk("rst_async_wake", sio.sysio_piu_wakeup, 4'h0);
    chk("rst_async_lpmd", sio.core_pad_lpmd_b, 8'hFF);
    model_reset();
    sio.int_in = '0;
    sio.piu_sysio_lpmd_b = 8'hFF;
    @(negedge sysio_clk);
    ticks(2);
    cpurst = 1'b0;
    ticks(3);
    chk("rst_release", sio.sysio_piu_wakeup, 4'h0);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      sio.apb_clk_en = ($urandom_range(0, 3) != 0);
      sio.axim_clk_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) sio.int_in = ($urandom_range(0, 1) != 0) ? 24'(1 << $urandom_range(0, 23)) : '0;
      if ($urandom_range(0, 2) == 0) sio.pad_core_dbgrq_b = 4'($urandom);
      if ($urandom_range(0, 5) == 0) sio.piu_sysio_lpmd_b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      sio.piu_sysio_jdb_pm = 8'($urandom);
      sio.pad_core_dbg_mask = 1'($urandom);
      tick();
    end

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
